// File: rtl/chroma_h_upsampler.sv
// Horizontal 4:2:2 -> 4:4:4 chroma upsampler.
// Reads packed half-width U and V planes from frame memory, one 16-bit word
// (two samples) at a time, and writes full-width planes where even pixels
// copy the source sample and odd pixels are the rounded average of the two
// neighbouring samples. The last odd pixel of a row replicates the edge.
//
// Handshake: start is a single-cycle request that is only accepted while
// busy is low. busy stays high from acceptance until the cycle in which the
// one-cycle done pulse is shown. wen qualifies waddr/wdata in the same cycle.
module chroma_h_upsampler #(
  parameter int W          = 320,
  parameter int H          = 240,
  parameter int U_SRC_BASE = 115200,
  parameter int V_SRC_BASE = 134400,
  parameter int U_DST_BASE = 38400,
  parameter int V_DST_BASE = 76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] rdata,
  output logic [17:0] raddr,
  output logic [17:0] waddr,
  output logic [15:0] wdata,
  output logic        wen,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  localparam int WPR = W / 4;                          // source words per row
  localparam int KW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW  = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_WR_EVEN = 3'd3,
    S_WR_ODD  = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            plane_q, plane_d;               // 0 = U, 1 = V
  logic [RW-1:0]   row_q, row_d;
  logic [KW-1:0]   k_q, k_d;
  logic [15:0]     cur_q, cur_d;
  logic [17:0]     raddr_q, raddr_d;
  logic [17:0]     waddr_q, waddr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            wen_q, wen_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [17:0]     dst_row_base;
  logic [17:0]     src_next_row;
  logic            k_last;
  logic            k_prefetch;
  logic            row_last;

  // Rounded mean of two 8-bit samples; the 9-bit sum cannot overflow.
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  assign dst_row_base = plane_q ? 18'(V_DST_BASE + int'(row_q) * (W / 2))
                                : 18'(U_DST_BASE + int'(row_q) * (W / 2));
  assign src_next_row = plane_q ? 18'(V_SRC_BASE + (int'(row_q) + 1) * WPR)
                                : 18'(U_SRC_BASE + (int'(row_q) + 1) * WPR);
  assign k_last       = (k_q == KW'(WPR - 1));
  // After this word pair, is there still a following word to fetch ahead?
  assign k_prefetch   = (int'(k_q) + 2 < WPR);
  assign row_last     = (row_q == RW'(H - 1));

  // State and registered outputs; reset clears everything and aborts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      plane_q <= 1'b0;
      row_q   <= '0;
      k_q     <= '0;
      cur_q   <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      row_q   <= row_d;
      k_q     <= k_d;
      cur_q   <= cur_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: raddr is loaded one state ahead so the synchronous
  // memory returns the word exactly when CAPTURE / WR_ODD consume it.
  always_comb begin
    logic [7:0] nxt;
    state_d = state_q;
    plane_d = plane_q;
    row_d   = row_q;
    k_d     = k_q;
    cur_d   = cur_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nxt     = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          plane_d = 1'b0;
          row_d   = '0;
          k_d     = '0;
          raddr_d = 18'(U_SRC_BASE);
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        cur_d   = rdata;
        if (!k_last) raddr_d = raddr_q + 18'd1;
        state_d = S_WR_EVEN;
      end
      S_WR_EVEN: begin
        wen_d   = 1'b1;
        wdata_d = {avg8(cur_q[7:0], cur_q[15:8]), cur_q[7:0]};
        waddr_d = dst_row_base + 18'(2 * int'(k_q));
        state_d = S_WR_ODD;
      end
      S_WR_ODD: begin
        nxt     = k_last ? cur_q[15:8] : rdata[7:0];
        wen_d   = 1'b1;
        wdata_d = {avg8(cur_q[15:8], nxt), cur_q[15:8]};
        waddr_d = dst_row_base + 18'(2 * int'(k_q) + 1);
        cur_d   = rdata;
        if (!k_last) begin
          k_d     = k_q + KW'(1);
          if (k_prefetch) raddr_d = raddr_q + 18'd1;
          state_d = S_WR_EVEN;
        end else begin
          k_d = '0;
          if (!row_last) begin
            row_d   = row_q + RW'(1);
            raddr_d = src_next_row;
            state_d = S_FETCH;
          end else if (!plane_q) begin
            plane_d = 1'b1;
            row_d   = '0;
            raddr_d = 18'(V_SRC_BASE);
            state_d = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign raddr     = raddr_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wen       = wen_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_chroma_h_upsampler.sv
// Bench for chroma_h_upsampler on a small frame so that several complete
// frames fit in a short run. Expected writes come from a pixel-level model
// of the upsampling rule applied to the bench's own copy of memory.
module tb_chroma_h_upsampler;

  localparam int W   = 16;
  localparam int H   = 6;
  localparam int USB = 1000;
  localparam int VSB = 1024;
  localparam int UDB = 200;
  localparam int VDB = 248;
  localparam int FRAME_CYC = 2 * H * (2 + W / 2) + 2;   // 122
  localparam int FRAME_WR  = 2 * H * W / 2;             // 96

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] rdata;
  logic [17:0] raddr;
  logic [17:0] waddr;
  logic [15:0] wdata;
  logic        wen;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  logic [15:0] mem [0:2047];
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  int compares;
  int mism;

  chroma_h_upsampler #(
    .W(W), .H(H),
    .U_SRC_BASE(USB), .V_SRC_BASE(VSB),
    .U_DST_BASE(UDB), .V_DST_BASE(VDB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rdata(rdata),
    .raddr(raddr), .waddr(waddr), .wdata(wdata), .wen(wen),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read memory model
  always @(posedge clk) rdata <= mem[raddr[10:0]];

  // write monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst === 1'b0 && wen === 1'b1) got_q.push_back({waddr, wdata});
  end

  // ---------------- reference model ----------------
  function automatic int src_sample(input int base, input int row, input int m);
    logic [15:0] w;
    w = mem[base + row * (W / 4) + m / 2];
    return (m % 2 == 1) ? int'(w[15:8]) : int'(w[7:0]);
  endfunction

  function automatic void build_expected();
    int sb, db, a, b, hi;
    exp_q.delete();
    for (int plane = 0; plane < 2; plane++) begin
      sb = (plane == 0) ? USB : VSB;
      db = (plane == 0) ? UDB : VDB;
      for (int row = 0; row < H; row++) begin
        for (int i = 0; i < W / 2; i++) begin
          a  = src_sample(sb, row, i);
          hi = a;
          if (i + 1 < W / 2) begin
            b  = src_sample(sb, row, i + 1);
            hi = (a + b + 1) / 2;
          end
          exp_q.push_back({18'(db + row * (W / 2) + i), 8'(hi), 8'(a)});
        end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_random();
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom_range(0, 65535));
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < 2048; i++) mem[i] = v;
  endtask

  // Pulse start, optionally re-pulse while busy, and wait (bounded) for done.
  // cyc returns the cycle of the first done after start (-1 if none).
  task automatic run_frame(input bit repulse, output int cyc, output int ndone);
    int n;
    int done_at;
    n = 0;
    ndone = 0;
    done_at = -1;
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    while (n < FRAME_CYC + 400 && (done_at < 0 || n < done_at + 8)) begin
      @(negedge clk);
      n++;
      start = (repulse && (n == 10 || n == 70)) ? 1'b1 : 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
    end
    start = 1'b0;
    cyc = done_at;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    compares += 7;
    if (raddr !== 18'd0) begin mism++; $display("FAIL reset_raddr: got %0d want 0", raddr); end
    if (waddr !== 18'd0) begin mism++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
    if (wdata !== 16'd0) begin mism++; $display("FAIL reset_wdata: got %h want 0000", wdata); end
    if (wen !== 1'b0) begin mism++; $display("FAIL reset_wen: got %b want 0", wen); end
    if (busy !== 1'b0) begin mism++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin mism++; $display("FAIL reset_done: got %b want 0", done); end
    if (dbg_state !== 3'd0) begin mism++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_flat();
    int cyc, nd;
    fill_const(16'h8080);
    run_frame(1'b0, cyc, nd);
    compares += 4;
    if (cyc != FRAME_CYC) begin mism++; $display("FAIL flat_cycles: got %0d want %0d", cyc, FRAME_CYC); end
    if (nd != 1) begin mism++; $display("FAIL flat_done_count: got %0d want 1", nd); end
    if (got_q.size() != FRAME_WR) begin mism++; $display("FAIL flat_writes: got %0d want %0d", got_q.size(), FRAME_WR); end
    if (busy !== 1'b0) begin mism++; $display("FAIL flat_busy_after: got %b want 0", busy); end
    for (int i = 0; i < got_q.size(); i++) begin
      compares++;
      if (got_q[i] !== {18'(UDB + i), 16'h8080}) begin
        mism++;
        $display("FAIL flat_write[%0d]: got addr %0d data %h want addr %0d data 8080",
                 i, got_q[i][33:16], got_q[i][15:0], UDB + i);
      end
    end
  endtask

  task automatic test_ramp();
    int cyc, nd;
    fill_random();
    for (int k = 0; k < W / 4; k++) mem[USB + k] = {8'(2 * k + 1), 8'(2 * k)};
    build_expected();
    run_frame(1'b0, cyc, nd);
    compares += 4;
    if (got_q.size() != exp_q.size()) begin mism++; $display("FAIL ramp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() >= W / 2) begin
      if (got_q[0][15:0] !== 16'h0100) begin mism++; $display("FAIL ramp_word0: got %h want 0100", got_q[0][15:0]); end
      if (got_q[1][15:0] !== 16'h0201) begin mism++; $display("FAIL ramp_word1: got %h want 0201", got_q[1][15:0]); end
      if (got_q[W/2-1][15:0] !== 16'h0707) begin mism++; $display("FAIL ramp_edge: got %h want 0707", got_q[W/2-1][15:0]); end
    end else begin
      mism++; $display("FAIL ramp_short: got %0d writes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compares++;
      if (got_q[i] !== exp_q[i]) begin mism++; $display("FAIL ramp_write[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_rounding_and_boundary();
    int cyc, nd;
    fill_random();
    mem[USB]             = 16'h0201;             // c0=01 c1=02
    mem[USB + W / 4]     = 16'hFEFF;             // row1: c0=FF c1=FE
    mem[USB + W / 4 - 1] = 16'h1055;             // row0 last sample 0x10
    mem[USB + W / 4]     = {mem[USB + W / 4][15:8], 8'hFF};
    mem[VSB + W / 4 - 1] = 16'h1055;             // V row0 last sample 0x10
    mem[VSB + W / 4]     = 16'h33F0;             // V row1 first sample 0xF0
    build_expected();
    run_frame(1'b0, cyc, nd);
    compares += 1;
    if (got_q.size() != FRAME_WR) begin
      mism++; $display("FAIL round_count: got %0d want %0d", got_q.size(), FRAME_WR);
    end else begin
      compares += 4;
      if (got_q[0][15:0] !== 16'h0201) begin mism++; $display("FAIL round_up: got %h want 0201", got_q[0][15:0]); end
      if (got_q[W/2][15:0] !== 16'hFFFF) begin mism++; $display("FAIL round_top: got %h want FFFF", got_q[W/2][15:0]); end
      if (got_q[W/2-1][15:0] !== 16'h1010) begin mism++; $display("FAIL row_edge_u: got %h want 1010", got_q[W/2-1][15:0]); end
      if (got_q[H*W/2 + W/2-1][15:0] !== 16'h1010) begin
        mism++; $display("FAIL row_edge_v: got %h want 1010", got_q[H*W/2 + W/2-1][15:0]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compares++;
      if (got_q[i] !== exp_q[i]) begin mism++; $display("FAIL round_write[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_frames();
    int cyc, nd;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      build_expected();
      run_frame(1'b0, cyc, nd);
      compares += 2;
      if (cyc != FRAME_CYC) begin mism++; $display("FAIL rand_cycles[%0d]: got %0d want %0d", f, cyc, FRAME_CYC); end
      if (got_q.size() != exp_q.size()) begin mism++; $display("FAIL rand_count[%0d]: got %0d want %0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        compares++;
        if (got_q[i] !== exp_q[i]) begin mism++; $display("FAIL rand_write[%0d][%0d]: got %h want %h", f, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nd;
    fill_random();
    build_expected();
    run_frame(1'b1, cyc, nd);
    compares += 3;
    if (nd != 1) begin mism++; $display("FAIL restart_done_count: got %0d want 1", nd); end
    if (cyc != FRAME_CYC) begin mism++; $display("FAIL restart_cycles: got %0d want %0d", cyc, FRAME_CYC); end
    if (got_q.size() != exp_q.size()) begin mism++; $display("FAIL restart_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compares++;
      if (got_q[i] !== exp_q[i]) begin mism++; $display("FAIL restart_write[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, nd, stray;
    fill_random();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(70, 100)) @(negedge clk);   // inside the V plane
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    compares += 5;
    if (raddr !== 18'd0) begin mism++; $display("FAIL midrst_raddr: got %0d want 0", raddr); end
    if (waddr !== 18'd0) begin mism++; $display("FAIL midrst_waddr: got %0d want 0", waddr); end
    if (wdata !== 16'd0) begin mism++; $display("FAIL midrst_wdata: got %h want 0000", wdata); end
    if (wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mism++; $display("FAIL midrst_ctrl: got wen=%b busy=%b done=%b want 0 0 0", wen, busy, done);
    end
    if (dbg_state !== 3'd0) begin mism++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    stray = 0;
    got_q.delete();
    repeat (20) begin
      @(negedge clk);
      if (wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) stray++;
    end
    compares += 2;
    if (stray != 0) begin mism++; $display("FAIL midrst_idle: got %0d active cycles want 0", stray); end
    if (got_q.size() != 0) begin mism++; $display("FAIL midrst_writes: got %0d want 0", got_q.size()); end
    build_expected();
    run_frame(1'b0, cyc, nd);
    compares += 3;
    if (cyc != FRAME_CYC) begin mism++; $display("FAIL after_rst_cycles: got %0d want %0d", cyc, FRAME_CYC); end
    if (nd != 1) begin mism++; $display("FAIL after_rst_done: got %0d want 1", nd); end
    if (got_q.size() != exp_q.size()) begin mism++; $display("FAIL after_rst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compares++;
      if (got_q[i] !== exp_q[i]) begin mism++; $display("FAIL after_rst_write[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    compares = 0;
    mism     = 0;
    rst      = 1'b1;
    start    = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_flat();
    test_ramp();
    test_rounding_and_boundary();
    test_random_frames();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

endmodule
